// File: rtl/sop_sweep.sv
// Sweeps an N-input boolean function through all 2^N input rows, one per cycle,
// presenting each vector with its function value and counting the rows where it is 1.
module sop_sweep #(
   parameter int N = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              pos,
   input  logic [2**N-1:0]   mask,
   input  logic              hold,
   output logic [N-1:0]      vec,
   output logic              s,
   output logic              valid,
   output logic              busy,
   output logic              done,
   output logic [N:0]        ones_count
);

   localparam int M = 2**N;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [M-1:0]    mask_q;
   logic            pos_q;
   logic [N-1:0]    vec_next;
   logic            last_row;

   assign vec_next = vec + N'(1);
   assign last_row = (vec == N'(M - 1));

   // The function value is registered together with the vector, so s is
   // looked up from the row being stepped into, not the current one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mask_q     <= '0;
         pos_q      <= 1'b0;
         vec        <= '0;
         s          <= 1'b0;
         valid      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         ones_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= RUN;
                  mask_q     <= mask;
                  pos_q      <= pos;
                  vec        <= '0;
                  s          <= pos ? ~mask[0] : mask[0];
                  valid      <= 1'b1;
                  busy       <= 1'b1;
                  ones_count <= '0;
               end
            end
            RUN: begin
               if (!hold) begin
                  ones_count <= ones_count + (N+1)'(s);
                  if (last_row) begin
                     state <= DONE;
                     valid <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     vec <= vec_next;
                     s   <= pos_q ? ~mask_q[vec_next] : mask_q[vec_next];
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               valid <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sop_sweep.sv
// Scoreboard bench for sop_sweep: expected rows are queued at start and
// compared row by row as the sweep presents them; small N=1/N=8 instances too.
module tb_sop_sweep;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        pos;
   logic [15:0] mask;
   logic        hold;
   logic [3:0]  vec;
   logic        s;
   logic        valid;
   logic        busy;
   logic        done;
   logic [4:0]  ones_count;

   logic        start1, s1, valid1, busy1, done1;
   logic [1:0]  mask1;
   logic [0:0]  vec1;
   logic [1:0]  ones1;

   logic         start8, s8, valid8, busy8, done8;
   logic [255:0] mask8;
   logic [7:0]   vec8;
   logic [8:0]   ones8;

   typedef struct {
      logic [3:0] vec;
      logic       s;
   } row_t;

   row_t expQ[$];
   int   checkCount = 0;
   int   errorCount = 0;
   int   modelCount = 0;
   bit   inSweep    = 0;
   bit   expDone    = 0;

   sop_sweep #(.N(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pos(pos), .mask(mask), .hold(hold),
      .vec(vec), .s(s), .valid(valid), .busy(busy), .done(done), .ones_count(ones_count)
   );

   sop_sweep #(.N(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .pos(1'b0), .mask(mask1), .hold(1'b0),
      .vec(vec1), .s(s1), .valid(valid1), .busy(busy1), .done(done1), .ones_count(ones1)
   );

   sop_sweep #(.N(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .pos(1'b0), .mask(mask8), .hold(1'b0),
      .vec(vec8), .s(s8), .valid(valid8), .busy(busy8), .done(done8), .ones_count(ones8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Monitor: compares each presented row against the queue head at the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         expQ.delete();
         inSweep = 0;
         expDone = 0;
      end else begin
         checkOutput("done", done, expDone);
         if (expDone) begin
            checkOutput("ones_at_done", ones_count, modelCount);
            expDone = 0;
         end
         if (valid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_row", valid, 0);
            end else begin
               if (!inSweep) begin
                  modelCount = 0;
                  inSweep    = 1;
               end
               checkOutput("vec", vec, expQ[0].vec);
               checkOutput("s", s, expQ[0].s);
               checkOutput("ones_running", ones_count, modelCount);
               checkOutput("busy", busy, 1);
               if (!hold) begin
                  modelCount += int'(expQ[0].s);
                  void'(expQ.pop_front());
                  if (expQ.size() == 0) begin
                     inSweep = 0;
                     expDone = 1;
                  end
               end
            end
         end
      end
   end

   // Queues the expected rows, starts a sweep and follows it until done,
   // optionally holding, changing mask mid-sweep or aborting with reset.
   task automatic applyStimulus(input logic [15:0] m, input logic p, input int holdVec,
                                input int changeVec, input int abortVec, input bit keepStart,
                                input int expCycles);
      int   n;
      int   holdLeft;
      int   expOnes;
      bit   holdUsed;
      bit   finished;
      row_t r;
      expOnes  = 0;
      holdLeft = 0;
      holdUsed = 0;
      finished = 0;
      for (int i = 0; i < 16; i++) begin
         r.vec = 4'(i);
         r.s   = p ? ~m[i] : m[i];
         expOnes += int'(r.s);
         expQ.push_back(r);
      end
      mask  = m;
      pos   = p;
      start = 1'b1;
      @(posedge clk); #1;
      if (!keepStart) start = 1'b0;
      n = 0;
      for (int c = 0; c < 200 && !finished; c++) begin
         @(posedge clk); #1;
         n++;
         if (done) begin
            finished = 1;
         end else if (abortVec >= 0 && valid && int'(vec) == abortVec) begin
            rst_n = 1'b0;
            #1;
            checkOutput("abort_vec", vec, 0);
            checkOutput("abort_s", s, 0);
            checkOutput("abort_valid", valid, 0);
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_done", done, 0);
            checkOutput("abort_ones", ones_count, 0);
            return;
         end else begin
            if (changeVec >= 0 && int'(vec) == changeVec) mask = 16'h0000;
            if (holdLeft > 0) begin
               holdLeft--;
               if (holdLeft == 0) hold = 1'b0;
            end else if (!holdUsed && valid && int'(vec) == holdVec) begin
               hold     = 1'b1;
               holdLeft = 3;
               holdUsed = 1;
            end
         end
      end
      checkOutput("done_seen", finished, 1);
      checkOutput("done_cycle", n, expCycles);
      checkOutput("ones_final", ones_count, expOnes);
   endtask

   initial begin
      int n;
      rst_n  = 1'b0;
      start  = 1'b0;
      pos    = 1'b0;
      mask   = '0;
      hold   = 1'b0;
      start1 = 1'b0;
      mask1  = '1;
      start8 = 1'b0;
      mask8  = '1;
      #2;
      checkOutput("reset_vec", vec, 0);
      checkOutput("reset_valid", valid, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_ones", ones_count, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] T1 single minterm");
      applyStimulus(16'h0001, 1'b0, -1, -1, -1, 0, 16);
      @(posedge clk); #1;
      checkOutput("idle_vec_hold", vec, 15);
      checkOutput("idle_busy", busy, 0);
      @(posedge clk); #1;

      $display("[TB] T2 maxterm and all-ones");
      applyStimulus(16'h0001, 1'b1, -1, -1, -1, 0, 16);
      @(posedge clk); #1;
      applyStimulus(16'hFFFF, 1'b0, -1, -1, -1, 0, 16);
      @(posedge clk); #1;

      $display("[TB] T3 hold at row 5");
      applyStimulus(16'hA5C3, 1'b0, 5, -1, -1, 0, 19);
      @(posedge clk); #1;

      $display("[TB] T4 start held, mask changed mid-sweep");
      applyStimulus(16'h3C5A, 1'b1, -1, 7, -1, 1, 16);
      @(posedge clk); #1;
      checkOutput("t4_gap_valid", valid, 0);
      checkOutput("t4_gap_busy", busy, 0);
      applyStimulus(16'h0000, 1'b1, -1, -1, -1, 0, 16);
      @(posedge clk); #1;

      $display("[TB] T5 async reset at row 9");
      applyStimulus(16'h1234, 1'b0, -1, -1, 9, 0, 0);
      start = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus(16'h8001, 1'b0, -1, -1, -1, 0, 16);
      @(posedge clk); #1;

      $display("[TB] T6 N=1 and N=8 all-ones");
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      n = 0;
      for (int c = 0; c < 20 && !done1; c++) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("n1_done_cycle", n, 2);
      checkOutput("n1_ones", ones1, 2);
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      n = 0;
      for (int c = 0; c < 600 && !done8; c++) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("n8_done_cycle", n, 256);
      checkOutput("n8_ones", ones8, 256);
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
